// File: rtl/bus_memory_slave_if.sv
// Handshake/address group of the SAM external bus seen by the memory slave.
// Ready exists only when MEM_READY_EN is defined.
interface bus_memory_slave_if;
    logic       ALE;
    logic       En;
    logic       Rw;
    logic [7:0] Address_Bus;
    logic       Err;
`ifdef MEM_READY_EN
    logic       Ready;
`endif

    modport slave (
        input  ALE,
        input  En,
        input  Rw,
        input  Address_Bus,
`ifdef MEM_READY_EN
        output Ready,
`endif
        output Err
    );

    modport master (
        output ALE,
        output En,
        output Rw,
        output Address_Bus,
`ifdef MEM_READY_EN
        input  Ready,
`endif
        input  Err
    );
endinterface

// File: rtl/bus_memory_slave.sv
// Memory slave for the SAM multiplexed bus: ALE address latch, En/Rw strobed access, tristate read data.
// Define MEM_READY_EN to insert WAIT_CYCLES read wait states and expose Ready.
//
// state | meaning
// IDLE  | bus released, no read pending
// WAIT  | read data captured, counting down wait states (MEM_READY_EN only)
// DRIVE | rd_q driven onto Data_Bus
module bus_memory_slave #(
    parameter int DEPTH       = 64,
    parameter int ADDR_W      = 6,
    parameter int WAIT_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    bus_memory_slave_if.slave bus,
    // The data bus stays a plain inout so tristate resolution is visible at the boundary.
    inout  wire  [7:0]        Data_Bus
);

    typedef enum logic [1:0] {IDLE, WAIT, DRIVE} state_t;

    localparam logic [8:0] DEPTH_L = 9'(DEPTH);
`ifdef MEM_READY_EN
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
`else
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES) & 4'h0;
`endif

    state_t            state_q, state_d;
    logic [7:0]        addr_q;
    logic [7:0]        rd_q, rd_d;
    logic              err_q;
    logic [7:0]        mem [DEPTH];
    logic [7:0]        eff;
    logic [ADDR_W-1:0] idx;
    logic              oor;
`ifdef MEM_READY_EN
    logic [3:0]        cnt_q, cnt_d;
`endif

    assign eff = bus.ALE ? bus.Address_Bus : addr_q;
    assign idx = eff[ADDR_W-1:0];
    assign oor = {1'b0, eff} >= DEPTH_L;

    always_ff @(posedge clk) begin
        if (bus.En && !bus.Rw && !oor) begin
            mem[idx] <= Data_Bus;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            addr_q  <= 8'h00;
            rd_q    <= 8'h00;
            err_q   <= 1'b0;
`ifdef MEM_READY_EN
            cnt_q   <= 4'd0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
`ifdef MEM_READY_EN
            cnt_q   <= cnt_d;
`endif
            if (bus.ALE) begin
                addr_q <= bus.Address_Bus;
            end
            if (bus.En && oor) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
`ifdef MEM_READY_EN
        cnt_d   = cnt_q;
`endif
        if (!bus.Rw) begin
            state_d = IDLE;
`ifdef MEM_READY_EN
            cnt_d   = 4'd0;
`endif
        end else if (bus.En) begin
            rd_d = oor ? 8'h00 : mem[idx];
            if (WAIT_LOAD != 4'd0) begin
                state_d = WAIT;
`ifdef MEM_READY_EN
                cnt_d   = WAIT_LOAD;
`endif
            end else begin
                state_d = DRIVE;
            end
        end
`ifdef MEM_READY_EN
        else if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = DRIVE;
            end
        end
`endif
    end

    assign Data_Bus = (state_q == DRIVE) ? rd_q : 8'hzz;
    assign bus.Err  = err_q;
`ifdef MEM_READY_EN
    assign bus.Ready = (state_q != WAIT);
`endif

endmodule

// File: doc/bus_memory_slave.md
# bus_memory_slave

Synthesizable memory slave sitting directly downstream of the Very Half SAM core on its multiplexed external bus. It latches the address on ALE, commits writes, and drives read data onto the shared bidirectional data bus under the En/Rw handshake. It replaces the behavioural memory model used in simulation so the core can run on hardware. An optional wait-state engine with a Ready output is available for slower memory.

## Interface
- DEPTH, 64: number of 8-bit words.
- ADDR_W, 6: internal address width, equal to clog2(DEPTH).
- WAIT_CYCLES, 0: read wait states, 0–15. Used only when MEM_READY_EN is defined.

- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- ALE  input  1  address latch enable from the core.
- En  input  1  access strobe.
- Rw  input  1  1 = read, 0 = write.
- Address_Bus  input  8  address from the core.
- Data_Bus  inout  8  shared data bus; driven only while in DRIVE.
- Err  output  1  sticky out-of-range access flag.
- Ready  output  1  access complete / slave idle. Present only with MEM_READY_EN.

## Operation
- Address latch (addr_q, 8 bit):
  - Loaded from Address_Bus on a rising edge where ALE=1.
  - Effective address eff = ALE ? Address_Bus : addr_q, so ALE and En in the same cycle use the new address.
- Range check: eff >= DEPTH is out of range. On an out-of-range access (En=1):
  - writes are suppressed;
  - reads return 8'h00;
  - Err is set to 1 and holds until reset.
  - Otherwise memory is indexed by eff[ADDR_W-1:0].
- Write: on an edge with En=1 and Rw=0, mem[eff] <= Data_Bus. Writes are single-cycle in every state.
- State machine, states IDLE / WAIT / DRIVE, evaluated per edge in this priority order:
  - Rw=0 → IDLE; Data_Bus is released; wait counter cleared. Any concurrent write still commits.
  - En=1 and Rw=1 → rd_q <= mem[eff], or 8'h00 if out of range. Next state is WAIT if the wait count is nonzero, else DRIVE. This applies from any state, so a re-read while driving refreshes rd_q.
  - WAIT → decrement the counter; enter DRIVE when it reaches 1.
  - DRIVE with Rw=1 and En=0 → stay in DRIVE and keep driving rd_q.
  - Otherwise, hold the current state.
- Data_Bus = (state==DRIVE) ? rd_q : 8'hZZ.
- Memory contents are not reset. They are undefined until written.

## Timing
- Reset (rst=0, asynchronous):
  - state = IDLE, Data_Bus = Z, addr_q = 0, rd_q = 0, Err = 0, Ready = 1, wait counter = 0.
- Reset asserted mid-read releases Data_Bus immediately, without waiting for a clock edge.
- Read latency with a wait count of 0: read sampled at edge N; Data_Bus is valid after edge N and stable at edge N+1.
- Read latency with wait count W: data is driven after edge N+W.
  - Ready falls after edge N and rises after edge N+W, coincident with drive start.
  - Ready = 1 in IDLE and DRIVE; Ready = 0 in WAIT.
- Bus turnaround: the slave stops driving after the first edge where it samples Rw=0. The core must not drive Data_Bus before that edge.
- Write data is sampled at the same edge where En=1 and Rw=0.
- Err rises after the offending edge.

## Configuration
- MEM_READY_EN defined:
  - WAIT_CYCLES wait states are inserted on every read.
  - The Ready port exists.
- MEM_READY_EN undefined:
  - the wait count is forced to 0 and WAIT is unreachable;
  - the Ready port and the counter are not compiled.
- Write behaviour, Err and reset behaviour are identical in both builds.

## Test plan
- Reset: hold rst=0 for 2 cycles → Data_Bus=Z, Err=0, Ready=1, addr_q=0.
- Write then read:
  - ALE=1 with address 8'h0C; next cycle En=1, Rw=0, Data_Bus=8'hA5.
  - Then En=1, Rw=1 → Data_Bus=8'hA5 one edge later, held until Rw=0, then Z after that edge.
- Same-cycle ALE: ALE=1, En=1, Rw=1, Address_Bus=8'h13, mem[19]=8'h63 → Data_Bus=8'h63 after the edge; addr_q=8'h13.
- Out of range:
  - write 8'hFF to address 8'h40 → mem[0] unchanged, Err=1.
  - read from 8'h40 → Data_Bus=8'h00.
  - Err stays 1 until rst=0.
- Wait states: MEM_READY_EN defined, WAIT_CYCLES=3, read of mem[7]=8'hFD → Ready=0 for exactly 3 cycles, then Ready=1 with Data_Bus=8'hFD.
- Abort and reset:
  - Rw=0 during WAIT → IDLE; bus is never driven.
  - rst=0 asserted mid-DRIVE → Data_Bus=Z asynchronously, before the next clk edge.
